regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file (negedge write, x0 hardwired to zero).
- Arbitrates that port between the in-order pipeline writeback (port A, never stalled) and a long-latency unit such as mul/div or a slow MMIO load (port B, valid/ready).
- Maintains a per-register pending-write scoreboard so the issue stage can detect RAW and WAW hazards against outstanding long-latency results.
- Raises a pipeline hold when port B starves.

---
 rtl/regfile_wb_arbiter.sv | 70 +++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between pipeline writeback (A)
// and a long-latency unit (B), with a pending-write scoreboard and starvation-driven pipeline hold.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int NREG         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [4:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [4:0]        b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_long,
    input  logic [4:0]        issue_rd,
    input  logic [4:0]        chk_rs1,
    input  logic [4:0]        chk_rs2,
    input  logic [4:0]        chk_rd,
    output logic              hazard,
    output logic              pipe_hold,
    output logic [NREG-1:0]   busy_mask,
    output logic              RegWrite,
    output logic [4:0]        WriteRegAddr,
    output logic [DATA_W-1:0] WriteData
);
    logic              a_use, b_xfer, b_write;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              pipe_hold_q;

    assign a_use   = a_valid && a_rd != '0;
    assign b_ready = !a_use;
    assign b_xfer  = b_valid && b_ready;
    assign b_write = b_xfer && b_rd != '0;

    assign RegWrite     = a_use || b_write;
    assign WriteRegAddr = a_use ? a_rd : b_write ? b_rd : '0;
    assign WriteData    = a_use ? a_data : b_write ? b_data : '0;

    // A set after the clear lets a freshly issued op on the same register stay outstanding.
    always_comb begin
        busy_d = busy_q;
        if (b_xfer) busy_d[b_rd] = 1'b0;
        if (issue_long && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign wait_d = (!b_valid || b_xfer) ? '0 :
                    (wait_q == CNT_W'(STARVE_LIMIT)) ? wait_q : wait_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= '0;
            wait_q      <= '0;
            pipe_hold_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            wait_q      <= wait_d;
            pipe_hold_q <= wait_d == CNT_W'(STARVE_LIMIT);
        end
    end

    assign hazard    = !reset && (busy_q[chk_rs1] || busy_q[chk_rs2] || busy_q[chk_rd]);
    assign pipe_hold = pipe_hold_q;
    assign busy_mask = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors checked by a per-cycle behavioural model plus literal pins.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;
    logic        clk = 1'b0, reset = 1'b1;
    logic        a_valid = 0, b_valid = 0, issue_long = 0;
    logic [4:0]  a_rd = 0, b_rd = 0, issue_rd = 0, chk_rs1 = 0, chk_rs2 = 0, chk_rd = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic        b_ready, hazard, pipe_hold, RegWrite;
    logic [31:0] busy_mask, WriteData;
    logic [4:0]  WriteRegAddr;
    int          n_chk = 0, n_fail = 0;
    bit          run = 0;

    regfile_wb_arbiter #(.DATA_W(32), .NREG(32), .STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_long(issue_long), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .pipe_hold(pipe_hold), .busy_mask(busy_mask),
        .RegWrite(RegWrite), .WriteRegAddr(WriteRegAddr), .WriteData(WriteData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: set of registers awaiting a long result, and the length of the current starvation streak.
    logic [31:0] m_busy;
    int          m_streak;
    logic        m_a_owns, m_xfer;
    assign m_a_owns = a_valid && a_rd != 0;
    assign m_xfer   = b_valid && !m_a_owns;

    always @(posedge clk) begin
        if (reset) begin
            m_busy   <= '0;
            m_streak <= 0;
        end else begin
            m_streak <= (b_valid && !m_xfer) ? m_streak + 1 : 0;
            if (m_xfer) m_busy[b_rd] <= 1'b0;
            if (issue_long && issue_rd != 0) m_busy[issue_rd] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            logic        e_we, e_hz;
            logic [4:0]  e_addr;
            logic [31:0] e_data;
            e_we   = m_a_owns || (m_xfer && b_rd != 0);
            e_addr = m_a_owns ? a_rd : e_we ? b_rd : 5'd0;
            e_data = m_a_owns ? a_data : e_we ? b_data : 32'd0;
            e_hz   = !reset && ((chk_rs1 != 0 && m_busy[chk_rs1]) || (chk_rs2 != 0 && m_busy[chk_rs2]) ||
                                (chk_rd != 0 && m_busy[chk_rd]));
            chk("m_b_ready", {31'd0, b_ready}, {31'd0, !m_a_owns});
            chk("m_regwrite", {31'd0, RegWrite}, {31'd0, e_we});
            chk("m_addr", {27'd0, WriteRegAddr}, {27'd0, e_addr});
            chk("m_data", WriteData, e_data);
            chk("m_hazard", {31'd0, hazard}, {31'd0, e_hz});
            chk("m_pipe_hold", {31'd0, pipe_hold}, {31'd0, m_streak >= LIMIT});
            chk("m_busy_mask", busy_mask, m_busy);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        run = 1;
        cyc();
        reset = 0;
        #2 chk("rst_busy", busy_mask, 32'h0);
        chk("rst_hold", {31'd0, pipe_hold}, 32'd0);
        // RAW hazard on a pending long result, then its writeback clears it
        issue_long = 1; issue_rd = 5;
        cyc();
        issue_long = 0; chk_rs1 = 5;
        #2 chk("t1_busy", busy_mask, 32'h20);
        chk("t1_hazard", {31'd0, hazard}, 32'd1);
        b_valid = 1; b_rd = 5; b_data = 32'hDEADBEEF;
        #1 chk("t1_ready", {31'd0, b_ready}, 32'd1);
        chk("t1_we", {31'd0, RegWrite}, 32'd1);
        chk("t1_addr", {27'd0, WriteRegAddr}, 32'd5);
        chk("t1_data", WriteData, 32'hDEADBEEF);
        cyc();
        b_valid = 0;
        #2 chk("t1_busy_clr", busy_mask, 32'h0);
        chk("t1_hazard_clr", {31'd0, hazard}, 32'd0);
        // A beats B, B follows next cycle
        cyc();
        chk_rs1 = 0; a_valid = 1; a_rd = 3; a_data = 32'h11; b_valid = 1; b_rd = 7; b_data = 32'h77;
        #2 chk("t2_addr_a", {27'd0, WriteRegAddr}, 32'd3);
        chk("t2_data_a", WriteData, 32'h11);
        chk("t2_ready", {31'd0, b_ready}, 32'd0);
        cyc();
        a_valid = 0;
        #2 chk("t2_addr_b", {27'd0, WriteRegAddr}, 32'd7);
        chk("t2_data_b", WriteData, 32'h77);
        cyc();
        b_valid = 0;
        // Starvation raises pipe_hold after LIMIT waiting cycles
        cyc();
        a_valid = 1; a_rd = 2; a_data = 32'h22; b_valid = 1; b_rd = 8; b_data = 32'h88;
        for (int i = 0; i < LIMIT; i++) begin
            #2 chk("t3_hold_low", {31'd0, pipe_hold}, 32'd0);
            cyc();
        end
        #2 chk("t3_hold_high", {31'd0, pipe_hold}, 32'd1);
        chk("t3_a_wins", {27'd0, WriteRegAddr}, 32'd2);
        cyc();
        a_valid = 0;
        #2 chk("t3_b_addr", {27'd0, WriteRegAddr}, 32'd8);
        chk("t3_hold_still", {31'd0, pipe_hold}, 32'd1);
        cyc();
        b_valid = 0;
        #2 chk("t3_hold_clr", {31'd0, pipe_hold}, 32'd0);
        // a_rd==0 does not block B; issue to x0 sets nothing
        cyc();
        a_valid = 1; a_rd = 0; a_data = 32'h55; b_valid = 1; b_rd = 9; b_data = 32'h99;
        issue_long = 1; issue_rd = 0;
        #2 chk("t4_ready", {31'd0, b_ready}, 32'd1);
        chk("t4_addr", {27'd0, WriteRegAddr}, 32'd9);
        chk("t4_data", WriteData, 32'h99);
        cyc();
        a_valid = 0; b_valid = 0; issue_long = 0;
        #2 chk("t4_busy", busy_mask, 32'h0);
        // Same-cycle clear and set on reg 4: set wins
        issue_long = 1; issue_rd = 4;
        cyc();
        b_valid = 1; b_rd = 4; b_data = 32'h44;
        cyc();
        b_valid = 0; issue_long = 0; chk_rs2 = 4;
        #2 chk("t5_busy", busy_mask, 32'h10);
        chk("t5_hazard", {31'd0, hazard}, 32'd1);
        // A write to a busy register leaves its bit alone
        issue_long = 1; issue_rd = 6;
        cyc();
        issue_long = 0; a_valid = 1; a_rd = 6; a_data = 32'h66;
        cyc();
        a_valid = 0; chk_rs2 = 0;
        #2 chk("t5b_busy", busy_mask, 32'h50);
        // Reset mid-wait flushes scoreboard and starvation state
        issue_long = 1; issue_rd = 12;
        cyc();
        issue_long = 0; a_valid = 1; a_rd = 1; a_data = 32'h1; b_valid = 1; b_rd = 12; b_data = 32'hC;
        chk_rd = 12;
        cyc();
        cyc();
        reset = 1;
        #2 chk("t6_hz_in_rst", {31'd0, hazard}, 32'd0);
        cyc();
        reset = 0; a_valid = 0; b_valid = 0;
        #2 chk("t6_busy", busy_mask, 32'h0);
        chk("t6_hold", {31'd0, pipe_hold}, 32'd0);
        chk("t6_hazard", {31'd0, hazard}, 32'd0);
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
